// File: rtl/mcb_read_check.sv
// rtl/mcb_read_check.sv - DDR3 MCB read-back pattern checker
// Issues one read burst per write-burst credit and checks returned words against the alternating pattern.
module mcb_read_check #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 30,
  parameter int                 BURST_LEN = 64,
  parameter logic [ADDR_W-1:0]  ADDR_INC  = 30'h400,
  parameter logic [ADDR_W-1:0]  END_ADDR  = 30'h0FFFFC00,
  parameter logic [DATA_W-1:0]  PATTERN_A = 32'hAAAAAAAA,
  parameter int                 TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              wr_burst_done_i,
  output logic              cmd_en_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [5:0]        cmd_bl_o,
  input  logic              cmd_full_i,
  output logic              rd_en_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_empty_i,
  input  logic              rd_overflow_i,
  input  logic              rd_error_i,
  output logic              busy_o,
  output logic              err_flag_o,
  output logic              timeout_flag_o,
  output logic [15:0]       err_count_o,
  output logic [31:0]       burst_count_o
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        credit_q, credit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        word_q, word_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_flag_q, err_flag_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       burst_q, burst_d;
  logic [DATA_W-1:0] exp_word;
  logic              cmd_fire;
  logic              pop;

  // Strobes are gated by reset so a reset asserted mid-burst never issues a stray command or pop.
  assign cmd_fire = rst_n && (state_q == S_CMD) && !cmd_full_i;
  assign pop      = rst_n && (state_q == S_DATA) && !rd_empty_i;
  assign exp_word = word_q[0] ? ~PATTERN_A : PATTERN_A;

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    addr_d     = addr_q;
    word_d     = word_q;
    timer_d    = timer_q;
    err_flag_d = err_flag_q;
    timeout_d  = timeout_q;
    err_cnt_d  = err_cnt_q;
    burst_d    = burst_q;

    case ({wr_burst_done_i, cmd_fire})
      2'b10: if (credit_q != 8'hFF) credit_d = credit_q + 8'd1;
      2'b01: credit_d = credit_q - 8'd1;
      default: credit_d = credit_q;
    endcase

    if (rd_overflow_i || rd_error_i) err_flag_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i && (credit_q != 8'd0)) state_d = S_CMD;
      end
      S_CMD: begin
        if (!cmd_full_i) begin
          state_d = S_DATA;
          word_d  = 7'd0;
          timer_d = '0;
        end
      end
      S_DATA: begin
        if (!rd_empty_i) begin
          if (rd_data_i != exp_word) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          word_d  = word_q + 7'd1;
          timer_d = '0;
          if (word_q == 7'(BURST_LEN - 1)) state_d = S_NEXT;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // Abort on the TIMEOUT-th idle cycle; any late words stay in the MCB FIFO.
          timeout_d = 1'b1;
          state_d   = S_NEXT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        burst_d = burst_q + 32'd1;
        addr_d  = (addr_q == END_ADDR) ? '0 : addr_q + ADDR_INC;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      credit_q   <= 8'd0;
      addr_q     <= '0;
      word_q     <= 7'd0;
      timer_q    <= '0;
      err_flag_q <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= 16'd0;
      burst_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      timer_q    <= timer_d;
      err_flag_q <= err_flag_d;
      timeout_q  <= timeout_d;
      err_cnt_q  <= err_cnt_d;
      burst_q    <= burst_d;
    end
  end

  assign cmd_en_o       = cmd_fire;
  assign cmd_addr_o     = addr_q;
  assign cmd_bl_o       = 6'(BURST_LEN - 1);
  assign rd_en_o        = pop;
  assign busy_o         = (state_q != S_IDLE);
  assign err_flag_o     = err_flag_q;
  assign timeout_flag_o = timeout_q;
  assign err_count_o    = err_cnt_q;
  assign burst_count_o  = burst_q;

endmodule

// File: tb/tb_mcb_read_check.sv
// tb/tb_mcb_read_check.sv - scoreboard bench for mcb_read_check
module tb_mcb_read_check;

  localparam logic [31:0] PA = 32'hAAAAAAAA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic        cmd_full = 1'b0;
  logic        rd_ov = 1'b0;
  logic        rd_er = 1'b0;
  logic        fifo_flush = 1'b0;
  logic        cmd_en, rd_en, rd_empty, busy, err_flag, timeout_flag;
  logic [29:0] cmd_addr;
  logic [5:0]  cmd_bl;
  logic [31:0] rd_data, burst_count;
  logic [15:0] err_count;

  logic [31:0] mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int          errors = 0;
  int          checks = 0;
  int          cmd_seen = 0;
  int          pop_seen = 0;
  logic [29:0] exp_addr [$];
  logic [29:0] mon_a;

  mcb_read_check #(.END_ADDR(30'h1000)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .wr_burst_done_i(wr),
    .cmd_en_o(cmd_en), .cmd_addr_o(cmd_addr), .cmd_bl_o(cmd_bl), .cmd_full_i(cmd_full),
    .rd_en_o(rd_en), .rd_data_i(rd_data), .rd_empty_i(rd_empty),
    .rd_overflow_i(rd_ov), .rd_error_i(rd_er),
    .busy_o(busy), .err_flag_o(err_flag), .timeout_flag_o(timeout_flag),
    .err_count_o(err_count), .burst_count_o(burst_count)
  );

  always #5 clk = ~clk;

  // MCB read FIFO model
  assign rd_data  = mem[rd_ptr[7:0]];
  assign rd_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (rd_en) rd_ptr <= rd_ptr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_en) begin
      cmd_seen++;
      if (exp_addr.size() == 0) begin
        check("unexpected_cmd_en", {31'd0, cmd_en}, 32'd0);
      end else begin
        mon_a = exp_addr.pop_front();
        check("cmd_addr", {2'b0, cmd_addr}, {2'b0, mon_a});
        check("cmd_bl", {26'd0, cmd_bl}, 32'd63);
      end
    end
    if (rd_en) pop_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wr();
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic load_burst(input int bad_idx, input logic [31:0] bad_val);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = (i % 2 == 1) ? ~PA : PA;
      if (i == bad_idx) w = bad_val;
      mem[wr_ptr % 256] = w;
      wr_ptr++;
    end
  endtask

  task automatic wait_bursts(input int target, input string name);
    int n;
    n = 0;
    while (burst_count != target && n < 3000) begin
      tick();
      n++;
    end
    check(name, burst_count, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int base_pop, base_cmd, n;

    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_cmd_en", {31'd0, cmd_en}, 0);
    check("rst_rd_en", {31'd0, rd_en}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err_flag", {31'd0, err_flag}, 0);
    check("rst_timeout", {31'd0, timeout_flag}, 0);
    check("rst_err_count", {16'd0, err_count}, 0);
    check("rst_burst_count", burst_count, 0);
    check("rst_cmd_addr", {2'b0, cmd_addr}, 0);
    check("rst_cmd_bl", {26'd0, cmd_bl}, 63);
    rst_n = 1'b1;
    start = 1'b1;
    tick();

    // 1: clean burst
    load_burst(-1, 0);
    exp_addr.push_back(30'h0);
    base_pop = pop_seen;
    base_cmd = cmd_seen;
    pulse_wr();
    wait_bursts(1, "t1_burst_count");
    check("t1_pops", pop_seen - base_pop, 64);
    check("t1_cmds", cmd_seen - base_cmd, 1);
    check("t1_err_count", {16'd0, err_count}, 0);
    check("t1_err_flag", {31'd0, err_flag}, 0);
    check("t1_next_addr", {2'b0, cmd_addr}, 32'h400);
    check("t1_busy", {31'd0, busy}, 0);

    // 2: word 5 corrupted
    load_burst(5, 32'h00000000);
    exp_addr.push_back(30'h400);
    base_pop = pop_seen;
    pulse_wr();
    wait_bursts(2, "t2_burst_count");
    check("t2_pops", pop_seen - base_pop, 64);
    check("t2_err_count", {16'd0, err_count}, 1);
    check("t2_err_flag", {31'd0, err_flag}, 1);
    check("t2_next_addr", {2'b0, cmd_addr}, 32'h800);

    // 3: cmd_full back-pressure
    cmd_full = 1'b1;
    load_burst(-1, 0);
    base_cmd = cmd_seen;
    pulse_wr();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_cmd_en", {31'd0, cmd_en}, 0);
      tick();
    end
    check("t3_busy_in_cmd", {31'd0, busy}, 1);
    exp_addr.push_back(30'h800);
    cmd_full = 1'b0;
    wait_bursts(3, "t3_burst_count");
    check("t3_single_cmd", cmd_seen - base_cmd, 1);
    repeat (5) tick();
    check("t3_credit_spent", {31'd0, busy}, 0);
    check("t3_next_addr", {2'b0, cmd_addr}, 32'hC00);
    check("t3_err_flag_sticky", {31'd0, err_flag}, 1);

    // 4: wr_burst_done coincident with cmd_en, address wrap at END_ADDR
    load_burst(-1, 0);
    load_burst(-1, 0);
    exp_addr.push_back(30'hC00);
    exp_addr.push_back(30'h1000);
    pulse_wr();
    tick();
    check("t4_cmd_en_now", {31'd0, cmd_en}, 1);
    pulse_wr();
    wait_bursts(5, "t4_burst_count");
    check("t4_wrapped_addr", {2'b0, cmd_addr}, 0);
    repeat (10) tick();
    check("t4_idle_after", {31'd0, busy}, 0);
    check("t4_no_extra_burst", burst_count, 5);
    check("t4_err_count", {16'd0, err_count}, 1);

    // 5: empty FIFO -> timeout
    exp_addr.push_back(30'h0);
    base_pop = pop_seen;
    pulse_wr();
    n = 0;
    while (!timeout_flag && n < 1200) begin
      tick();
      n++;
    end
    check("t5_timeout_flag", {31'd0, timeout_flag}, 1);
    check("t5_timeout_cycles", n, 1025);
    check("t5_pops", pop_seen - base_pop, 0);
    tick();
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_burst_count", burst_count, 6);
    check("t5_next_addr", {2'b0, cmd_addr}, 32'h400);

    // 6: reset at word 30
    load_burst(-1, 0);
    exp_addr.push_back(30'h400);
    base_pop = pop_seen;
    pulse_wr();
    n = 0;
    while (pop_seen - base_pop < 30 && n < 500) begin
      tick();
      n++;
    end
    check("t6_reached_word30", pop_seen - base_pop, 30);
    rst_n = 1'b0;
    fifo_flush = 1'b1;
    tick();
    check("t6_cmd_en", {31'd0, cmd_en}, 0);
    check("t6_rd_en", {31'd0, rd_en}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_err_flag", {31'd0, err_flag}, 0);
    check("t6_timeout", {31'd0, timeout_flag}, 0);
    check("t6_err_count", {16'd0, err_count}, 0);
    check("t6_burst_count", burst_count, 0);
    check("t6_cmd_addr", {2'b0, cmd_addr}, 0);
    rst_n = 1'b1;
    fifo_flush = 1'b0;
    repeat (10) tick();
    check("t6_credit_cleared", {31'd0, busy}, 0);
    check("t6_cmds_drained", exp_addr.size(), 0);

    // rd_error sets the sticky flag without counting a mismatch
    rd_er = 1'b1;
    tick();
    rd_er = 1'b0;
    tick();
    check("rderr_flag", {31'd0, err_flag}, 1);
    check("rderr_count", {16'd0, err_count}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
